// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage for a core with a 16-bit instruction input. Sequences the PC,
//   fetches over a single-outstanding req/ack interface, buffers fetched words
//   in a DEPTH-entry prefetch queue and presents the head with valid/ready.
//   A Redirect pulse flushes the queue and restarts fetch at RedirectPC; an
//   in-flight request is completed on the bus but its data is discarded.
//
// Build option:
//   FETCH_STATS_EN  when defined, adds the FetchCount output, a 16-bit wrapping
//                   counter of accepted pops (InstrValid && InstrReady, no
//                   Redirect in the same cycle).
//
// Ports:
//   CLK, RESET_N            clock (rising edge), asynchronous active-low reset
//   IMemReq/IMemAddr        fetch request and address, held until IMemAck
//   IMemAck/IMemData        one-cycle acknowledge with the fetched word
//   Redirect/RedirectPC     flush pulse and new fetch address
//   Instruction/InstrPC     queue head word and its address (0 when empty)
//   InstrValid/InstrReady   downstream handshake; pop on both high
//   FetchCount              accepted-pop counter (FETCH_STATS_EN only)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic               IMemReq,
    output logic [ADDR_W-1:0]  IMemAddr,
    input  logic               IMemAck,
    input  logic [INSTR_W-1:0] IMemData,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectPC,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  InstrPC,
    output logic               InstrValid,
    input  logic               InstrReady
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        FetchCount
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, SQUASH} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  req_addr;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               issue;
    logic               push;
    logic               pop;

    logic [ADDR_W-1:0]  q_pc   [DEPTH];
    logic [INSTR_W-1:0] q_data [DEPTH];

    // Next-state logic. A request is only issued from FETCH, so at most one is
    // outstanding and the queue always has room for the word it returns.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        case (state)
            FETCH: begin
                if (!Redirect && (count < FULL_CNT)) begin
                    issue     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (IMemAck) begin
                    push      = !Redirect;
                    state_nxt = FETCH;
                end else if (Redirect) begin
                    state_nxt = SQUASH;
                end
            end
            SQUASH: begin
                // The word returned here belongs to the pre-redirect stream.
                if (IMemAck) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign pop = InstrValid && InstrReady && !Redirect;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            // Separate address register keeps IMemAddr stable through SQUASH
            // even though pc already holds the redirect target.
            if (issue) begin
                req_addr <= pc;
            end
            if (Redirect) begin
                pc     <= RedirectPC;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + ADDR_W'(1);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: queue storage has no reset; entries are only observed when count
    // says they hold data, so clearing them would add logic for nothing.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_pc[wr_ptr]   <= pc;
            q_data[wr_ptr] <= IMemData;
        end
    end

    assign IMemReq     = (state != FETCH);
    assign IMemAddr    = req_addr;
    assign InstrValid  = (count != '0);
    assign Instruction = InstrValid ? q_data[rd_ptr] : '0;
    assign InstrPC     = InstrValid ? q_pc[rd_ptr]   : '0;

`ifdef FETCH_STATS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            FetchCount <= '0;
        end else if (pop) begin
            FetchCount <= FetchCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (RESET_PC = 0x10, DEPTH = 4).
// Reference model: a queue of {pc, data} entries, the next fetch address, and
// the request rules expressed per cycle; memory image has the address in the
// upper byte of every word so misrouted data is obvious.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [7:0] RST_PC = 8'h10;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IMemReq;
    logic [7:0]  IMemAddr;
    logic        IMemAck = 1'b0;
    logic [15:0] IMemData = '0;
    logic        Redirect = 1'b0;
    logic [7:0]  RedirectPC = '0;
    logic [15:0] Instruction;
    logic [7:0]  InstrPC;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
`ifdef FETCH_STATS_EN
    logic [15:0] FetchCount;
`endif

    instr_fetch_unit #(
        .ADDR_W(8), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(RST_PC)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemAck(IMemAck), .IMemData(IMemData),
        .Redirect(Redirect), .RedirectPC(RedirectPC),
        .Instruction(Instruction), .InstrPC(InstrPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady)
`ifdef FETCH_STATS_EN
        , .FetchCount(FetchCount)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] data;
    } entry_t;

    typedef struct {
        logic       rdy;
        logic       exp_req;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_ipc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [256];

    // reference model state
    entry_t      q[$];
    logic [7:0]  fetch_pc;
    logic [7:0]  held_addr;
    logic        prev_req, prev_ack, prev_redirect, just_reset, squash_pending;
    int          prev_occ;
    logic [15:0] fc_model;

    // memory responder state
    int   ack_delay = 0;
    int   wait_cnt = 0;
    logic rand_lat = 1'b0;

    int             cyc = 0;
    logic [23:0]    pop_log[$];
    logic [7:0]     req_log[$];
    int             req_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        fetch_pc       = RST_PC;
        held_addr      = RST_PC;
        prev_req       = 1'b0;
        prev_ack       = 1'b0;
        prev_redirect  = 1'b0;
        prev_occ       = 0;
        just_reset     = 1'b1;
        squash_pending = 1'b0;
        fc_model       = '0;
        wait_cnt       = 0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        IMemAck = 1'b0; IMemData = '0; Redirect = 1'b0; RedirectPC = '0; InstrReady = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    // One clock cycle: compare outputs with the model, act as memory, drive
    // inputs, advance the model, then move to the next falling edge.
    task automatic step(input logic rdy, input logic redir, input logic [7:0] rpc);
        entry_t head;
        logic   exp_req, ack_now, new_req;
        head = '0;
        if (q.size() != 0) head = q[0];
        check("instr_valid", InstrValid, q.size() != 0);
        check("instr_pc", InstrPC, head.pc);
        check("instruction", Instruction, head.data);
        if (just_reset)    exp_req = 1'b0;
        else if (prev_req) exp_req = !prev_ack;
        else               exp_req = !prev_redirect && (prev_occ < DEPTH);
        check("imem_req", IMemReq, exp_req);
        new_req = IMemReq && !prev_req;
        if (IMemReq) check("imem_addr", IMemAddr, new_req ? fetch_pc : held_addr);
`ifdef FETCH_STATS_EN
        check("fetch_count", FetchCount, fc_model);
`endif
        ack_now = 1'b0;
        if (IMemReq) begin
            if (wait_cnt >= ack_delay) begin
                ack_now  = 1'b1;
                wait_cnt = 0;
                if (rand_lat) ack_delay = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        IMemAck    = ack_now;
        IMemData   = ack_now ? mem[IMemAddr] : 16'($urandom);
        InstrReady = rdy;
        Redirect   = redir;
        RedirectPC = rpc;

        if (new_req) begin
            held_addr = fetch_pc;
            req_log.push_back(IMemAddr);
            req_cyc.push_back(cyc);
        end
        if (InstrValid && rdy && !redir) pop_log.push_back({InstrPC, Instruction});

        prev_occ      = q.size();
        prev_req      = IMemReq;
        prev_ack      = ack_now;
        prev_redirect = redir;
        just_reset    = 1'b0;
        if (redir) begin
            q.delete();
            squash_pending = IMemReq && !ack_now;
            fetch_pc       = rpc;
        end else begin
            if (q.size() != 0 && rdy) begin
                void'(q.pop_front());
                fc_model++;
            end
            if (IMemReq && ack_now) begin
                if (squash_pending) begin
                    squash_pending = 1'b0;
                end else begin
                    q.push_back({fetch_pc, mem[fetch_pc]});
                    fetch_pc++;
                end
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    vec_t tbl[16];

    initial begin
        int   found;
        logic [23:0] e;

        for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'($urandom)};

        tbl[0]  = '{1'b0, 1'b0, 8'h10, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h10, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b0, 8'h10, 1'b1, 8'h10};
        tbl[3]  = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h10};
        tbl[4]  = '{1'b0, 1'b0, 8'h11, 1'b1, 8'h10};
        tbl[5]  = '{1'b0, 1'b1, 8'h12, 1'b1, 8'h10};
        tbl[6]  = '{1'b0, 1'b0, 8'h12, 1'b1, 8'h10};
        tbl[7]  = '{1'b0, 1'b1, 8'h13, 1'b1, 8'h10};
        tbl[8]  = '{1'b0, 1'b0, 8'h13, 1'b1, 8'h10};
        tbl[9]  = '{1'b0, 1'b0, 8'h13, 1'b1, 8'h10};
        tbl[10] = '{1'b0, 1'b0, 8'h13, 1'b1, 8'h10};
        tbl[11] = '{1'b0, 1'b0, 8'h13, 1'b1, 8'h10};
        tbl[12] = '{1'b1, 1'b0, 8'h13, 1'b1, 8'h10};
        tbl[13] = '{1'b0, 1'b0, 8'h13, 1'b1, 8'h11};
        tbl[14] = '{1'b0, 1'b1, 8'h14, 1'b1, 8'h11};
        tbl[15] = '{1'b0, 1'b0, 8'h14, 1'b1, 8'h11};

        // Fill with no consumer, immediate acks; then one pop refills one slot.
        rand_lat = 1'b0; ack_delay = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("tbl_req[%0d]", i), IMemReq, tbl[i].exp_req);
            check($sformatf("tbl_addr[%0d]", i), IMemAddr, tbl[i].exp_addr);
            check($sformatf("tbl_valid[%0d]", i), InstrValid, tbl[i].exp_valid);
            check($sformatf("tbl_ipc[%0d]", i), InstrPC, tbl[i].exp_ipc);
            check($sformatf("tbl_instr[%0d]", i), Instruction,
                  tbl[i].exp_valid ? mem[tbl[i].exp_ipc] : 16'h0);
            step(tbl[i].rdy, 1'b0, 8'h00);
        end

        // In-order stream with one wait cycle per fetch.
        ack_delay = 1;
        do_reset();
        pop_log.delete();
        repeat (40) step(1'b1, 1'b0, 8'h00);
        check("seq_pops", pop_log.size() >= 10, 1);
        for (int i = 0; i < 10 && i < pop_log.size(); i++) begin
            e = pop_log[i];
            check($sformatf("seq_pc[%0d]", i), e[23:16], 8'(RST_PC + i));
            check($sformatf("seq_data[%0d]", i), e[15:0], mem[8'(RST_PC + i)]);
        end

        // Redirect while waiting on 0x12; the late ack must be dropped.
        ack_delay = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 50; i++) begin
            if (IMemReq && IMemAddr == 8'h12) begin
                found = 1;
                break;
            end
            step(1'b1, 1'b0, 8'h00);
        end
        check("redir_found_wait", found, 1);
        pop_log.delete();
        step(1'b1, 1'b1, 8'h40);
        repeat (25) step(1'b1, 1'b0, 8'h00);
        check("redir_pops", pop_log.size() >= 2, 1);
        if (pop_log.size() >= 2) begin
            e = pop_log[0];
            check("redir_first_pc", e[23:16], 8'h40);
            check("redir_first_data", e[15:0], mem[8'h40]);
            e = pop_log[1];
            check("redir_second_pc", e[23:16], 8'h41);
        end

        // Address wrap, free-running without stalls.
        ack_delay = 0;
        do_reset();
        step(1'b1, 1'b1, 8'hFE);
        req_log.delete(); req_cyc.delete();
        repeat (12) step(1'b1, 1'b0, 8'h00);
        check("wrap_reqs", req_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            check($sformatf("wrap_addr[%0d]", i), req_log[i], 8'(8'hFE + i));
            if (i > 0) check($sformatf("wrap_gap[%0d]", i), req_cyc[i] - req_cyc[i-1], 2);
        end

        // Asynchronous reset in the middle of a request with two entries held.
        ack_delay = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 2 && IMemReq) begin
                found = 1;
                break;
            end
            step(1'b0, 1'b0, 8'h00);
        end
        check("areset_found", found, 1);
        check("areset_pre_valid", InstrValid, 1);
        #2;
        RESET_N = 1'b0;
        IMemAck = 1'b0; InstrReady = 1'b0; Redirect = 1'b0;
        #1;
        check("areset_req", IMemReq, 0);
        check("areset_addr", IMemAddr, RST_PC);
        check("areset_valid", InstrValid, 0);
        check("areset_ipc", InstrPC, 0);
        check("areset_instr", Instruction, 0);
`ifdef FETCH_STATS_EN
        check("areset_fetch_count", FetchCount, 0);
`endif
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        ack_delay = 1;
        for (int i = 0; i < 60; i++) step(($urandom_range(0, 1) == 1), (i == 30), 8'h80);

        // Randomized traffic against the model.
        rand_lat = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
